// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition evaluation and gating of PC/register/memory write enables.
module cond_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);
  logic       cond_ex_delayed;
  logic [1:0] flag_write;
  logic       n, z, c, v;
  assign {n, z, c, v} = Flags;
  always_comb begin
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = n == v;
      4'b1011: CondEx = n != v;
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end
  // The undelayed result gates flag writes, so a flag-setting instruction tests the old flags.
  assign flag_write = FlagW & {2{CondEx}};
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags           <= FLAGS_RST;
      cond_ex_delayed <= 1'b0;
    end else begin
      if (flag_write[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flag_write[0]) Flags[1:0] <= ALUFlags[1:0];
      cond_ex_delayed <= CondEx;
    end
  end
  assign RegWrite = ~reset & RegW & cond_ex_delayed;
  assign MemWrite = ~reset & MemW & cond_ex_delayed;
  assign PCWrite  = ~reset & ((PCS & cond_ex_delayed) | NextPC);
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed vector table, full condition sweep and random stimulus against a flag/condition model.
module tb_cond_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
  int passed = 0;
  int total = 0;
  logic [3:0] m_flags = 4'b0000;
  bit         m_ced = 1'b0;

  cond_unit #(.FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondEx(CondEx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       pcs, npc, rw, mw;
    logic [3:0] e_flags;
    logic       e_cex, e_pcw, e_rw, e_mw;
  } vec_t;

  // Conditions come in complementary pairs: even code tests a predicate, odd code its negation.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit pn, pz, pc, pv, base;
    pn = f[3]; pz = f[2]; pc = f[1]; pv = f[0];
    base = 1'b0;
    case (c[3:1])
      3'd0: base = pz;
      3'd1: base = pc;
      3'd2: base = pn;
      3'd3: base = pv;
      3'd4: base = pc && !pz;
      3'd5: base = (pn == pv);
      3'd6: base = !pz && (pn == pv);
      default: return c[0] == 1'b0;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic apply(input vec_t t);
    reset = t.rst; Cond = t.cond; ALUFlags = t.alu; FlagW = t.fw;
    PCS = t.pcs; NextPC = t.npc; RegW = t.rw; MemW = t.mw;
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic step(input bit use_model, input vec_t t);
    bit ok;
    @(negedge clk);
    ok = cond_ok(Cond, m_flags);
    if (use_model) begin
      chk("flags", Flags, m_flags);
      chk("condex", {3'b0, CondEx}, {3'b0, ok});
      chk("pcwrite", {3'b0, PCWrite}, {3'b0, !reset && ((PCS && m_ced) || NextPC)});
      chk("regwrite", {3'b0, RegWrite}, {3'b0, !reset && RegW && m_ced});
      chk("memwrite", {3'b0, MemWrite}, {3'b0, !reset && MemW && m_ced});
    end else begin
      chk("vec_flags", Flags, t.e_flags);
      chk("vec_condex", {3'b0, CondEx}, {3'b0, t.e_cex});
      chk("vec_pcwrite", {3'b0, PCWrite}, {3'b0, t.e_pcw});
      chk("vec_regwrite", {3'b0, RegWrite}, {3'b0, t.e_rw});
      chk("vec_memwrite", {3'b0, MemWrite}, {3'b0, t.e_mw});
    end
    @(posedge clk);
    if (reset) begin
      m_flags = 4'b0000;
      m_ced = 1'b0;
    end else begin
      if (FlagW[1] && ok) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && ok) m_flags[1:0] = ALUFlags[1:0];
      m_ced = ok;
    end
    #1;
  endtask

  vec_t vecs[18];
  vec_t v;

  initial begin
    //        rst cond     alu      fw     pcs npc rw mw | flags   cex pcw rw mw
    vecs[0]  = '{1, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 1,  4'bxxxx, 1, 0, 0, 0};
    vecs[1]  = '{0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0,  4'b0000, 1, 1, 0, 0};
    vecs[2]  = '{0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0,  4'b0000, 1, 0, 0, 0};
    vecs[3]  = '{0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0,  4'b0100, 1, 0, 0, 0};
    vecs[4]  = '{0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0,  4'b0100, 1, 0, 1, 0};
    vecs[5]  = '{0, 4'b0001, 4'b0000, 2'b00, 1, 0, 1, 1,  4'b0100, 0, 1, 1, 1};
    vecs[6]  = '{0, 4'b0001, 4'b0000, 2'b00, 1, 0, 1, 1,  4'b0100, 0, 0, 0, 0};
    vecs[7]  = '{0, 4'b0001, 4'b0000, 2'b00, 1, 1, 1, 1,  4'b0100, 0, 1, 0, 0};
    vecs[8]  = '{1, 4'b1110, 4'b0000, 2'b11, 1, 1, 1, 1,  4'b0100, 1, 0, 0, 0};
    vecs[9]  = '{0, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0,  4'b0000, 1, 0, 0, 0};
    vecs[10] = '{0, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0,  4'b1100, 1, 0, 0, 0};
    vecs[11] = '{0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0,  4'b1111, 1, 0, 0, 0};
    vecs[12] = '{0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0,  4'b1111, 1, 0, 0, 0};
    vecs[13] = '{0, 4'b0001, 4'b0000, 2'b11, 0, 0, 0, 0,  4'b0100, 0, 0, 0, 0};
    vecs[14] = '{0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0,  4'b0100, 0, 0, 0, 0};
    vecs[15] = '{0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0,  4'b0100, 1, 0, 0, 0};
    vecs[16] = '{1, 4'b1110, 4'b0000, 2'b11, 1, 0, 1, 1,  4'b0100, 1, 0, 0, 0};
    vecs[17] = '{0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0,  4'b0000, 0, 0, 0, 0};
    apply(vecs[0]);
    @(negedge clk);
    chk("reset_pcwrite", {3'b0, PCWrite}, 4'b0);
    chk("reset_regwrite", {3'b0, RegWrite}, 4'b0);
    chk("reset_memwrite", {3'b0, MemWrite}, 4'b0);
    @(posedge clk);
    #1;
    for (int i = 1; i < 18; i++) begin
      apply(vecs[i]);
      step(1'b0, vecs[i]);
    end
    // Model state now mirrors the post-table DUT state (flags 0000 after the reset, Cond=EQ false).
    m_flags = 4'b0000;
    m_ced = 1'b0;
    for (int f = 0; f < 16; f++) begin
      v = '{0, 4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0};
      apply(v);
      step(1'b1, v);
      for (int c = 0; c < 16; c++) begin
        v = '{0, 4'(c), 4'b0000, 2'b00, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0};
        apply(v);
        step(1'b1, v);
      end
    end
    for (int i = 0; i < 400; i++) begin
      v.rst = ($urandom_range(0, 19) == 0);
      v.cond = 4'($urandom);
      v.alu = 4'($urandom);
      v.fw = 2'($urandom);
      v.pcs = 1'($urandom);
      v.npc = 1'($urandom);
      v.rw = 1'($urandom);
      v.mw = 1'($urandom);
      apply(v);
      step(1'b1, v);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
